// File: rtl/mem_access_stage.sv
// MEM pipeline stage: byte/half/word loads and stores against an internal word memory,
// with optional wait states that stall upstream, and registered MEM/WB outputs.
module mem_access_stage #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0,
  parameter int PC_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_wdata,
  input  logic [31:0]       in_alu_res,
  input  logic [4:0]        in_reg_dst,
  input  logic [1:0]        in_wb_res_mux,
  input  logic [PC_W-1:0]   in_next_pc,
  input  logic              in_branch_taken,
  output logic              stall,
  output logic              out_valid,
  output logic [31:0]       out_mem_data,
  output logic [31:0]       out_alu_res,
  output logic [4:0]        out_reg_dst,
  output logic [1:0]        out_wb_res_mux,
  output logic [PC_W-1:0]   out_next_pc,
  output logic              out_branch_taken,
  output logic              out_misalign
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t            state, state_next;
  logic [3:0]        cnt, cnt_next;
  logic              complete;
  logic [31:0]       mem [DEPTH];

  logic              mem_op, misalign, access;
  logic [IDX_W-1:0]  idx;
  logic [31:0]       rd_word, shifted, load_data, wlane, merged;
  logic [3:0]        be;

  // Address bits above the word index are intentionally ignored (memory wraps).
  logic unused_addr_bits;
  assign unused_addr_bits = ^in_addr[ADDR_W-1:IDX_W+2];

  assign mem_op   = in_valid & (in_mem_read | in_mem_write);
  assign misalign = mem_op & ((in_size == 2'b11) ||
                              (in_size == 2'b01 && in_addr[0]) ||
                              (in_size == 2'b10 && in_addr[1:0] != 2'b00));
  assign access   = mem_op & ~misalign;
  assign idx      = in_addr[IDX_W+1:2];
  assign rd_word  = mem[idx];
  assign shifted  = rd_word >> {in_addr[1:0], 3'b000};

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    stall      = 1'b0;
    complete   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (access && WAIT_STATES > 0) begin
          stall      = 1'b1;
          cnt_next   = 4'(WAIT_STATES);
          state_next = (WAIT_STATES > 1) ? S_WAIT : S_DONE;
        end else begin
          complete = 1'b1;
        end
      end
      S_WAIT: begin
        stall    = 1'b1;
        cnt_next = cnt - 4'd1;
        if (cnt <= 4'd2) state_next = S_DONE;
      end
      S_DONE: begin
        complete   = 1'b1;
        cnt_next   = 4'd0;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Narrow stores replicate the low byte/half across lanes; byte enables pick the target.
  always_comb begin
    be    = 4'b0000;
    wlane = in_wdata;
    unique case (in_size)
      2'b00: begin
        be    = 4'b0001 << in_addr[1:0];
        wlane = {4{in_wdata[7:0]}};
      end
      2'b01: begin
        be    = in_addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{in_wdata[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    for (int k = 0; k < 4; k++)
      merged[8*k +: 8] = be[k] ? wlane[8*k +: 8] : rd_word[8*k +: 8];
  end

  always_comb begin
    load_data = 32'd0;
    unique case (in_size)
      2'b00:   load_data = {{24{~in_unsigned & shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = {{16{~in_unsigned & shifted[15]}}, shifted[15:0]};
      2'b10:   load_data = rd_word;
      default: load_data = 32'd0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: the data memory has no reset; contents survive rst like a real RAM.
  always_ff @(posedge clk) begin
    if (!rst && complete && access && in_mem_write)
      mem[idx] <= merged;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid        <= 1'b0;
      out_misalign     <= 1'b0;
      out_mem_data     <= 32'd0;
      out_alu_res      <= 32'd0;
      out_reg_dst      <= 5'd0;
      out_wb_res_mux   <= 2'd0;
      out_next_pc      <= '0;
      out_branch_taken <= 1'b0;
    end else if (complete) begin
      out_valid        <= in_valid;
      out_misalign     <= misalign;
      out_mem_data     <= (access && in_mem_read && !in_mem_write) ? load_data : 32'd0;
      out_alu_res      <= in_alu_res;
      out_reg_dst      <= in_reg_dst;
      out_wb_res_mux   <= in_wb_res_mux;
      out_next_pc      <= in_next_pc;
      out_branch_taken <= in_branch_taken;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: one instance with no wait states, one with three,
// sharing stimulus; expected load results flow through a scoreboard queue.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_mem_read, in_mem_write, in_unsigned, in_branch_taken;
  logic [1:0]  in_size, in_wb_res_mux;
  logic [31:0] in_addr, in_wdata, in_alu_res, in_next_pc;
  logic [4:0]  in_reg_dst;

  logic        st0, v0, mis0, bt0, st3, v3, mis3, bt3;
  logic [31:0] md0, alu0, pc0, md3, alu3, pc3;
  logic [4:0]  rd0, rd3;
  logic [1:0]  wm0, wm3;

  logic        sel;  // 0 observes the zero-wait instance, 1 the three-wait instance
  logic        o_stall, o_valid, o_mis;
  logic [31:0] o_data;

  typedef struct {
    logic [31:0] data;
    logic        mis;
  } exp_t;
  exp_t expq[$];

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_size(in_size), .in_unsigned(in_unsigned),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_alu_res(in_alu_res),
    .in_reg_dst(in_reg_dst), .in_wb_res_mux(in_wb_res_mux), .in_next_pc(in_next_pc),
    .in_branch_taken(in_branch_taken), .stall(st0), .out_valid(v0),
    .out_mem_data(md0), .out_alu_res(alu0), .out_reg_dst(rd0),
    .out_wb_res_mux(wm0), .out_next_pc(pc0), .out_branch_taken(bt0),
    .out_misalign(mis0));

  mem_access_stage #(.WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_size(in_size), .in_unsigned(in_unsigned),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_alu_res(in_alu_res),
    .in_reg_dst(in_reg_dst), .in_wb_res_mux(in_wb_res_mux), .in_next_pc(in_next_pc),
    .in_branch_taken(in_branch_taken), .stall(st3), .out_valid(v3),
    .out_mem_data(md3), .out_alu_res(alu3), .out_reg_dst(rd3),
    .out_wb_res_mux(wm3), .out_next_pc(pc3), .out_branch_taken(bt3),
    .out_misalign(mis3));

  always_comb begin
    o_stall = sel ? st3  : st0;
    o_valid = sel ? v3   : v0;
    o_mis   = sel ? mis3 : mis0;
    o_data  = sel ? md3  : md0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wd);
    in_valid = v; in_mem_read = rd; in_mem_write = wr; in_size = sz;
    in_unsigned = uns; in_addr = addr; in_wdata = wd;
    in_alu_res = 32'd0; in_reg_dst = 5'd0; in_wb_res_mux = 2'd0;
    in_next_pc = 32'd0; in_branch_taken = 1'b0;
  endtask

  // Issue one memory op, wait (bounded) for its result, and score latency, stalls and data.
  task automatic run_op(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_data, input logic exp_mis, input int exp_lat);
    int cycles = 0;
    int stalls = 0;
    bit got = 0;
    exp_t e;
    drive(1'b1, rd, wr, sz, uns, addr, wd);
    expq.push_back('{data: exp_data, mis: exp_mis});
    while (!got && cycles < 20) begin
      @(negedge clk);
      if (o_stall) stalls++;
      @(posedge clk); #1;
      cycles++;
      if (o_valid === 1'b1) got = 1;
    end
    check({tag, " latency"}, cycles, exp_lat);
    check({tag, " stalls"}, stalls, exp_lat - 1);
    if (got) begin
      e = expq.pop_front();
      check({tag, " data"}, o_data, e.data);
      check({tag, " misalign"}, {31'd0, o_mis}, {31'd0, e.mis});
    end
  endtask

  initial begin
    sel = 1'b0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst out_valid", {31'd0, v0}, 32'd0);
    check("rst misalign", {31'd0, mis0}, 32'd0);
    check("rst mem_data", md0, 32'd0);
    check("rst alu_res", alu0, 32'd0);
    check("rst next_pc", pc0, 32'd0);
    check("rst stall3", {31'd0, st3}, 32'd0);
    check("rst out_valid3", {31'd0, v3}, 32'd0);
    rst = 1'b0;

    // Zero wait states: back-to-back ops, one cycle each, stall never set.
    run_op("sw 10",      0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1);
    run_op("lw 10",      1, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 1);
    run_op("sb 11",      0, 1, 2'b00, 0, 32'h11, 32'h12345680, 32'h0, 0, 1);
    run_op("lb 11",      1, 0, 2'b00, 0, 32'h11, 32'h0, 32'hFFFFFF80, 0, 1);
    run_op("lbu 11",     1, 0, 2'b00, 1, 32'h11, 32'h0, 32'h00000080, 0, 1);
    run_op("lw 10 b",    1, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEAD80EF, 0, 1);
    run_op("lh 13 mis",  1, 0, 2'b01, 0, 32'h13, 32'h0, 32'h0, 1, 1);
    run_op("sh 13 mis",  0, 1, 2'b01, 0, 32'h13, 32'hFFFFFFFF, 32'h0, 1, 1);
    run_op("size11",     1, 0, 2'b11, 0, 32'h0, 32'h0, 32'h0, 1, 1);
    run_op("lw 10 c",    1, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEAD80EF, 0, 1);
    run_op("lh 12",      1, 0, 2'b01, 0, 32'h12, 32'h0, 32'hFFFFDEAD, 0, 1);
    run_op("lhu 10",     1, 0, 2'b01, 1, 32'h10, 32'h0, 32'h000080EF, 0, 1);
    run_op("sw wrap",    0, 1, 2'b10, 0, 32'h1004, 32'hCAFEF00D, 32'h0, 0, 1);
    run_op("lw 4",       1, 0, 2'b10, 0, 32'h4, 32'h0, 32'hCAFEF00D, 0, 1);
    run_op("rw both",    1, 1, 2'b10, 0, 32'h8, 32'h5A5A5A5A, 32'h0, 0, 1);
    run_op("lw 8",       1, 0, 2'b10, 0, 32'h8, 32'h0, 32'h5A5A5A5A, 0, 1);

    // Pass-through payload, then a bubble.
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    in_alu_res = 32'h1234; in_reg_dst = 5'd7; in_wb_res_mux = 2'd2;
    in_next_pc = 32'h40; in_branch_taken = 1'b1;
    @(posedge clk); #1;
    check("pt valid", {31'd0, v0}, 32'd1);
    check("pt alu", alu0, 32'h1234);
    check("pt reg_dst", {27'd0, rd0}, 32'd7);
    check("pt wb_mux", {30'd0, wm0}, 32'd2);
    check("pt next_pc", pc0, 32'h40);
    check("pt branch", {31'd0, bt0}, 32'd1);
    check("pt misalign", {31'd0, mis0}, 32'd0);
    in_valid = 1'b0; in_alu_res = 32'h5678;
    @(posedge clk); #1;
    check("bubble valid", {31'd0, v0}, 32'd0);
    check("bubble alu", alu0, 32'h5678);

    // Three wait states.
    sel = 1'b1;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op("ws3 sw 20",  0, 1, 2'b10, 0, 32'h20, 32'h11111111, 32'h0, 0, 4);
    drive(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h99999999);
    repeat (3) @(posedge clk);
    #1;
    check("ws3 idle stall", {31'd0, st3}, 32'd0);
    run_op("ws3 lw 20",  1, 0, 2'b10, 0, 32'h20, 32'h0, 32'h11111111, 0, 4);

    // Reset in the middle of a waited store: nothing is written.
    drive(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h22222222);
    repeat (2) @(posedge clk);
    #1;
    check("ws3 mid stall", {31'd0, st3}, 32'd1);
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("ws3 rst valid", {31'd0, v3}, 32'd0);
    check("ws3 rst stall", {31'd0, st3}, 32'd0);
    rst = 1'b0;
    run_op("ws3 lw old", 1, 0, 2'b10, 0, 32'h20, 32'h0, 32'h11111111, 0, 4);
    run_op("ws3 mis",    1, 0, 2'b10, 0, 32'h22, 32'h0, 32'h0, 1, 1);
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
    check("scoreboard empty", expq.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Parametrised pipeline MEM stage for the lapido core, sitting between the EX/MEM and MEM/WB boundaries. It performs byte/half/word loads and stores against an internal word-organised data memory, with a configurable number of wait states and a stall output that holds the upstream stages. It flags misaligned accesses and registers all write-back controls and data into the MEM/WB outputs.

## Interface
- `ADDR_W`, 32, byte-address width of `in_addr`.
- `DEPTH`, 1024, data memory size in 32-bit words (power of two).
- `WAIT_STATES`, 0, extra cycles per memory access (0..15).
- `PC_W`, 32, program counter width.

- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: EX/MEM holds a live instruction.
- `in_mem_read` in 1: load.
- `in_mem_write` in 1: store.
- `in_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `in_unsigned` in 1: zero-extend loads (else sign-extend).
- `in_addr` in ADDR_W: byte address.
- `in_wdata` in 32: store data; the low byte/half is used for narrow stores.
- `in_alu_res` in 32, `in_reg_dst` in 5, `in_wb_res_mux` in 2, `in_next_pc` in PC_W, `in_branch_taken` in 1: pass-through payload.
- `stall` out 1: hold EX/MEM and earlier stages this cycle.
- `out_valid` out 1: MEM/WB holds a live instruction.
- `out_mem_data` out 32: extended load result.
- `out_alu_res`, `out_reg_dst`, `out_wb_res_mux`, `out_next_pc`, `out_branch_taken`: registered payload.
- `out_misalign` out 1: access was misaligned or had an illegal size and was suppressed.

## Operation
- A memory op is `in_valid & (in_mem_read | in_mem_write)`. If both read and write are set, the op is treated as a store and `out_mem_data` is 0.
- Word index is `in_addr[log2(DEPTH)+1:2]`. Higher address bits are ignored, so addresses wrap modulo DEPTH words.
- Byte lanes are little-endian: byte k occupies bits [8k+7:8k].
- Alignment rules:
  - Half requires `addr[0]=0`.
  - Word requires `addr[1:0]=0`.
  - Size 11 is always illegal.
- Misaligned or illegal op:
  - No memory access and no wait states.
  - Outputs `out_misalign=1`, `out_mem_data=0`, `out_valid=1`.
- Stores write only the addressed lanes; other bytes of the word are unchanged.
- Loads extract the addressed lane(s), then zero- or sign-extend per `in_unsigned`. Word loads ignore `in_unsigned`.
- FSM states:
  - IDLE: accept. A non-memory op, misaligned op, or memory op with WAIT_STATES=0 completes this cycle. A memory op with WAIT_STATES>0 loads `cnt=WAIT_STATES`, asserts `stall`, and goes to WAIT.
  - WAIT: `stall=1`; decrement `cnt`. When `cnt` reaches 1, go to DONE.
  - DONE: `stall=0`. The access executes (store committed, read data sampled) and the stage returns to IDLE.
- While `stall=1`, upstream must hold all `in_*` stable; the stage samples them only in the completing cycle.
- A store commits exactly once per instruction.
- `in_valid=0` produces a bubble: `out_valid=0` next cycle, and all other outputs register their inputs normally.
- Memory contents are not cleared by `rst`.

## Timing
- Reset values: `out_valid=0`, `out_misalign=0`, `stall=0`, all data/control outputs 0, FSM=IDLE, `cnt=0`.
- `rst` asserted mid-WAIT: return to IDLE next edge, no store commit, `out_valid=0`.
- `stall` is combinational from the FSM state and the IDLE-cycle inputs.
- Latency:
  - Non-memory and misaligned ops: one cycle.
  - Memory ops: 1+WAIT_STATES cycles; with WAIT_STATES=0 this equals one cycle.
- `out_*` update only in the completing cycle.
- In stalled cycles `out_valid=0` and the payload outputs hold their previous values.
- Back-to-back memory ops with WAIT_STATES=0 sustain one per cycle.
- Store then load to the same word on consecutive cycles: the load returns the new data (write commits on the first edge, read samples on the second).

## Test plan
- Reset, then word store 0xDEADBEEF @0x10, then word load @0x10 -> `out_mem_data=0xDEADBEEF`, `out_valid=1` one cycle after each accept, `stall` never set (WAIT_STATES=0).
- Byte store 0x80 @0x11, then byte loads @0x11 signed/unsigned -> 0xFFFFFF80 / 0x00000080; word load @0x10 -> 0xDEAD80EF.
- Half load @0x13 -> `out_misalign=1`, `out_mem_data=0`, memory unchanged; size 11 @0x0 -> `out_misalign=1`.
- WAIT_STATES=3, store @0x20:
  - `stall` high for 3 cycles from accept, `out_valid` on the 4th edge.
  - Inputs changed after completion are not written.
  - `rst` during WAIT -> no write, verified by a later readback of the old value.
- Address wrap: store @ (DEPTH*4 + 0x4) -> readable at @0x4.
- Pass-through: non-memory op with `alu_res=0x1234`, `reg_dst=7`, `wb_res_mux=2`, `next_pc=0x40`, `branch_taken=1` -> identical registered outputs next cycle; a bubble gives `out_valid=0`.
